// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multicycle CPU controller and its datapath:
//   - ctrlState_t : controller state enumeration
//   - OP_*        : supported IR[31:26] opcode values
//   - SRCB_*      : ALUSrcB mux encodings
//   - ALUOP_*     : ALUOp encodings given to the ALU control block
//   - PCSRC_*     : PCSource mux encodings
//   - isLegalOp() : true for every opcode the controller can execute
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } ctrlState_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_PCINC   = 2'b01;
  localparam logic [1:0] SRCB_SIGNEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEROEXT = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: isLegalOp = 1'b1;
      default:                                               isLegalOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// ---------------------------------------------------------------------------
// ctrl_output_decode
// Purely combinational state-to-control decode for the multicycle controller.
// Ports:
//   state      (in)  current controller state (ctrlState_t encoding)
//   opcode     (in)  live IR[31:26], only used to flag an illegal opcode in DECODE
//   latchedOp  (in)  opcode captured at DECODE exit, selects the IEXEC variant
//   memReady   (in)  effective memory-ready, gates PCWrite/IRWrite in FETCH
//   PCWrite .. PCSource, illegalOp (out) datapath enables/selects
// Every output defaults to 0 and is raised only in the states that use it.
// ---------------------------------------------------------------------------
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] latchedOp,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegalOp
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegalOp   = 1'b0;

    case (ctrlState_t'(state))
      S_FETCH: begin
        // PC+4 and IR load only commit once the instruction word is valid.
        MemRead = 1'b1;
        ALUSrcB = SRCB_PCINC;
        PCWrite = memReady;
        IRWrite = memReady;
      end
      S_DECODE: begin
        // Branch target speculatively computed while the opcode is decoded.
        ALUSrcB   = SRCB_SIGNEXT;
        illegalOp = ~isLegalOp(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SIGNEXT;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_IEXEC: begin
        // ori needs zero extension and OR; anything else reaching here is addi.
        ALUSrcA = 1'b1;
        if (latchedOp == OP_ORI) begin
          ALUSrcB = SRCB_ZEROEXT;
          ALUOp   = ALUOP_OR;
        end else begin
          ALUSrcB = SRCB_SIGNEXT;
          ALUOp   = ALUOP_ADD;
        end
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle MIPS-subset datapath
// (R-type, lw, sw, beq, j, addi, ori).
// Parameter:
//   MEM_HANDSHAKE  1: memory states wait for memReady; 0: memReady ignored.
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   opcode         IR[31:26]
//   memReady       memory access completes this cycle
//   PCWrite .. PCSource  datapath enables/selects (from ctrl_output_decode)
//   illegalOp      one-cycle pulse in DECODE on an unsupported opcode
//   instrCount     number of retired instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        memReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        illegalOp,
  output logic [31:0] instrCount
);

  ctrlState_t  stateReg;
  ctrlState_t  stateNext;
  logic [5:0]  latchedOpReg;
  logic [31:0] instrCountReg;
  logic        retire;
  logic        memReadyEff;

  assign memReadyEff = (MEM_HANDSHAKE != 0) ? memReady : 1'b1;

  // ---------------- next-state logic ----------------
  always_comb begin
    stateNext = stateReg;
    retire    = 1'b0;
    case (stateReg)
      S_FETCH:  stateNext = memReadyEff ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     stateNext = S_MEMADR;
          OP_RTYPE:         stateNext = S_RTEXEC;
          OP_BEQ:           stateNext = S_BRANCH;
          OP_J:             stateNext = S_JUMP;
          OP_ADDI, OP_ORI:  stateNext = S_IEXEC;
          default:          stateNext = S_FETCH;  // illegal: no retire
        endcase
      end
      // Only lw/sw reach MEMADR, so anything but sw is a load.
      S_MEMADR: stateNext = (latchedOpReg == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  stateNext = memReadyEff ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        stateNext = S_FETCH;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        if (memReadyEff) begin
          stateNext = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_RTEXEC: stateNext = S_RTWB;
      S_RTWB, S_BRANCH, S_JUMP, S_IWB: begin
        stateNext = S_FETCH;
        retire    = 1'b1;
      end
      S_IEXEC:  stateNext = S_IWB;
      default:  stateNext = S_FETCH;
    endcase
  end

  // ---------------- state, opcode latch, retire counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= S_FETCH;
      latchedOpReg  <= OP_RTYPE;
      instrCountReg <= 32'd0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == S_DECODE) begin
        latchedOpReg <= opcode;
      end
      if (retire) begin
        instrCountReg <= instrCountReg + 32'd1;  // natural wrap at 2^32
      end
    end
  end

  assign instrCount = instrCountReg;

  // ---------------- output decode ----------------
  // During reset the selects show the FETCH decode and every write enable
  // (plus illegalOp) is held low so nothing in the datapath is disturbed.
  logic [3:0] decodeState;
  logic       pcWriteRaw;
  logic       pcWriteCondRaw;
  logic       memWriteRaw;
  logic       irWriteRaw;
  logic       regWriteRaw;
  logic       illegalOpRaw;

  assign decodeState = reset ? S_FETCH : stateReg;

  ctrl_output_decode uDecode (
    .state       (decodeState),
    .opcode      (opcode),
    .latchedOp   (latchedOpReg),
    .memReady    (memReadyEff),
    .PCWrite     (pcWriteRaw),
    .PCWriteCond (pcWriteCondRaw),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (memWriteRaw),
    .IRWrite     (irWriteRaw),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (regWriteRaw),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegalOp   (illegalOpRaw)
  );

  assign PCWrite     = pcWriteRaw     & ~reset;
  assign PCWriteCond = pcWriteCondRaw & ~reset;
  assign MemWrite    = memWriteRaw    & ~reset;
  assign IRWrite     = irWriteRaw     & ~reset;
  assign RegWrite    = regWriteRaw    & ~reset;
  assign illegalOp   = illegalOpRaw   & ~reset;

endmodule
